// File: rtl/lmg_reader.sv
// Unpacks 160-bit move-FIFO words into up to eight moves, slot 0 first; slot 0 of a word is presented 3 cycles after a non-empty FIFO is seen in IDLE.
// Backpressure: a valid slot is held stable until mv_ready; invalid slots take one cycle each; outputs decode only from registered state.
module lmg_reader (
  input  logic         clk,
  input  logic         reset,
  input  logic         lmg_done,
  input  logic [159:0] fifoOut,
  input  logic         fifoEmpty,
  output logic         rden,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [6:0]   mv_flags,
  output logic [5:0]   mv_from,
  output logic [5:0]   mv_to,
  output logic [7:0]   mv_count,
  output logic         done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [6:0] flags;
    logic [5:0] from;
    logic [5:0] to;
  } mv_t;

  state_t       state_q, state_d;
  logic [151:0] word_q, word_d;
  logic [2:0]   slot_q, slot_d;
  logic [7:0]   count_q, count_d;
  logic         done_seen_q, done_seen_d;
  logic         empty_seen_q, empty_seen_d;

  mv_t  cur_mv;
  logic slot_vld;
  logic pad_unused;

  assign pad_unused = ^fifoOut[159:152];

  always_comb begin
    cur_mv = '0;
    for (int k = 0; k < 8; k++) begin
      if (slot_q == 3'(k)) cur_mv = word_q[151-19*k -: 19];
    end
  end

  // flags[6] marks an empty slot; the other flag bits are irrelevant then
  assign slot_vld = ~cur_mv.flags[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      slot_q       <= '0;
      count_q      <= '0;
      done_seen_q  <= 1'b0;
      empty_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      slot_q       <= slot_d;
      count_q      <= count_d;
      done_seen_q  <= done_seen_d;
      empty_seen_q <= empty_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    slot_d       = slot_q;
    count_d      = count_q;
    done_seen_d  = done_seen_q | lmg_done;
    empty_seen_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Two empty IDLE cycles in a row let a late final write land first
        empty_seen_d = fifoEmpty;
        if (!fifoEmpty) begin
          state_d = ST_REQ;
        end else if (done_seen_q && empty_seen_q) begin
          state_d = ST_FIN;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        word_d  = fifoOut[151:0];
        slot_d  = 3'd0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (slot_vld && mv_ready && (count_q != 8'hFF)) begin
          count_d = count_q + 8'd1;
        end
        if (!slot_vld || mv_ready) begin
          if (slot_q == 3'd7) begin
            state_d = ST_IDLE;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rden     = (state_q == ST_REQ);
  assign mv_valid = (state_q == ST_EMIT) && slot_vld;
  assign done     = (state_q == ST_FIN);
  assign mv_flags = cur_mv.flags;
  assign mv_from  = cur_mv.from;
  assign mv_to    = cur_mv.to;
  assign mv_count = count_q;

endmodule

// File: doc/lmg_reader.md
# lmg_reader

Consumer-side unpacker for the legal-move-generator FIFO. It pops 160-bit packed move words from the move FIFO and splits each into eight 19-bit move slots. Invalid slots are discarded, and each valid move goes to the downstream evaluator over a valid/ready handshake. It also counts emitted moves and signals completion once the generator is done and the FIFO is drained.

## Interface
- No parameters. Word format is fixed: 8 pad bits plus 8 slots of 19 bits each.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; same net that clears the move FIFO
- lmg_done  in  1  generator finished writing; level, sampled each cycle
- fifoOut  in  160  FIFO read data; valid the cycle after rden (normal, non-show-ahead FIFO)
- fifoEmpty  in  1  FIFO empty flag
- rden  out  1  FIFO read request; one-cycle pulse per word
- mv_valid  out  1  mv_flags/mv_from/mv_to hold a valid move
- mv_ready  in  1  downstream accepts the move when high together with mv_valid
- mv_flags  out  7  move flags
- mv_from  out  6  source square, octal rank/file as packed
- mv_to  out  6  destination square
- mv_count  out  8  number of moves accepted downstream; saturates at 255
- done  out  1  high once all words are consumed and lmg_done was seen

## Operation
Word layout:
- bits [159:152] are ignored.
- Slot k (k=0..7) occupies [151-19k : 133-19k].
- Within a slot: flags = top 7 bits, from = next 6, to = low 6.
- Slot 0 is emitted first.
- A slot is invalid when flags[6]=1 (7'h40 pattern). Lower flag bits do not matter for an invalid slot.

States:
- IDLE
  - fifoEmpty=0 → REQ.
  - Else if done_seen=1 and fifoEmpty has been 1 for two consecutive IDLE cycles → FIN.
- REQ: rden=1 for this cycle only → WAIT.
- WAIT: at the exit edge, capture fifoOut into word register; slot index ← 0 → EMIT.
- EMIT
  - Current slot valid: mv_valid=1, hold all move outputs stable until mv_ready=1. On the accept edge, mv_count += 1 (saturating) and advance the slot.
  - Current slot invalid: mv_valid=0 for one cycle, then advance the slot.
  - Advancing past slot 7 → IDLE.
- FIN: done=1. Terminal until reset. rden=0 and mv_valid=0.

Other rules:
- done_seen is a sticky register, set by lmg_done=1 in any state and cleared only by reset.
- The two-cycle empty check covers the writer's last write, which may land after lmg_done rises.
- rden, mv_valid and all move outputs are decoded from registered state only. There is no combinational path from mv_ready or fifoEmpty to any output.
- mv_flags/mv_from/mv_to are don't-care when mv_valid=0. Drive them from the current slot regardless of mv_valid.
- A word whose 8 slots are all invalid emits nothing and costs 8 EMIT cycles.

## Timing
- Reset values:
  - state=IDLE
  - rden=0, mv_valid=0, done=0
  - mv_count=0, done_seen=0
  - word register=0; the current slot therefore decodes as from=0, to=0, flags=0.
- Reset is asynchronous and may assert in any state, including mid-handshake. Outputs clear immediately, with no partial move left pending. A word being unpacked is lost; this is acceptable because the FIFO clears on the same reset.
- Latency with fifoEmpty low in IDLE at cycle t:
  - rden high in t+1.
  - Slot 0 presented in t+3.
- Throughput: one slot per cycle with mv_ready held high, so 11 cycles per word (REQ + WAIT + 8 EMIT + IDLE).
- Only one rden per word. rden is never asserted while fifoEmpty=1, because IDLE checks fifoEmpty before entering REQ.
- mv_count increments exactly on edges where mv_valid & mv_ready. At 255 it holds at 255.
- done rises in the cycle after the FIN transition decision and stays high.

## Test plan
- Single word with 8 valid pawn moves (01→02 … 71→72), mv_ready=1 → 8 moves in slot order from t+3, one per cycle; mv_count=8.
- Word with 4 knight moves then 4 slots of 7'h40 → exactly 4 moves (10→02, 10→22, 60→52, 60→72); 4 idle EMIT cycles; mv_count=4.
- Three words (8 + 8 + 4 valid) followed by lmg_done → 20 moves in order; done=1 after the FIFO drains; done stays high; exactly 3 rden pulses.
- Backpressure: mv_ready toggled randomly → no move lost or duplicated; outputs stable while mv_valid & !mv_ready; mv_count=8 per full word.
- lmg_done=1 with an empty FIFO from reset → no rden; done=1 within 4 cycles; mv_count=0.
- Reset asserted during EMIT slot 3 with mv_valid=1 → immediately mv_valid=0, mv_count=0, state IDLE; after release, a new word is processed normally.
